// File: rtl/sdram_pkg.sv
// Shared command encodings and refresh-sequencer state type for the SDRAM controller.
package sdram_pkg;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  localparam int PH_BITS = 8;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_REQ      = 4'd1,
    ST_PRE      = 4'd2,
    ST_PRE_WAIT = 4'd3,
    ST_AREF     = 4'd4,
    ST_RFC_WAIT = 4'd5,
    ST_SR_ENTER = 4'd6,
    ST_SR_HOLD  = 4'd7,
    ST_SR_EXIT  = 4'd8
  } ref_state_t;

  // The interval timer is frozen while the device owns its own refresh.
  function automatic logic is_sr_state(input ref_state_t s);
    return (s == ST_SR_ENTER) || (s == ST_SR_HOLD) || (s == ST_SR_EXIT);
  endfunction

endpackage

// File: rtl/ref_interval_timer.sv
// Periodic refresh interval counter; emits a one-cycle tick on the wrap cycle.
module ref_interval_timer #(
  parameter int REF_INTERVAL = 780,
  parameter int CNT_BITS     = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(REF_INTERVAL - 1);
  localparam logic [CNT_BITS-1:0] ONE  = CNT_BITS'(1);

  logic [CNT_BITS-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else if (en) begin
      count <= count + ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/sdram_refresh_ctrl.sv
// Refresh and self-refresh sequencer: tracks refresh debt, arbitrates for the
// command bus and issues PRECHARGE ALL / AUTO REFRESH / self-refresh sequences.
module sdram_refresh_ctrl
  import sdram_pkg::*;
#(
  parameter int REF_INTERVAL = 780,
  parameter int TRP          = 2,
  parameter int TRFC         = 7,
  parameter int CNT_BITS     = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       ref_en,
  input  logic       ref_gnt,
  input  logic       sr_req,
  input  logic       sx_done,
  input  logic [3:0] sx_command,
  output logic       ref_req,
  output logic       sr_ack,
  output logic       sx_start,
  output logic [3:0] command,
  output logic       cke,
  output logic       ref_overflow
);

  localparam logic [PH_BITS-1:0] PH_TRP  = PH_BITS'(TRP - 1);
  localparam logic [PH_BITS-1:0] PH_TRFC = PH_BITS'(TRFC - 1);
  localparam logic [PH_BITS-1:0] PH_ONE  = PH_BITS'(1);

  ref_state_t         state;
  ref_state_t         state_nxt;
  logic [2:0]         debt;
  logic [2:0]         debt_nxt;
  logic [PH_BITS-1:0] phase;
  logic               overflow;
  logic               tick;
  logic               debt_dec;
  logic               lost_tick;

  ref_interval_timer #(
    .REF_INTERVAL(REF_INTERVAL),
    .CNT_BITS    (CNT_BITS)
  ) u_timer (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (state == ST_SR_ENTER),
    .en   (ref_en && !is_sr_state(state)),
    .tick (tick)
  );

  // A simultaneous tick and AREF cancel; AREF with no debt (sr_req withdrawn) cannot underflow.
  always_comb begin
    debt_dec  = (state == ST_AREF) && (debt != 3'd0);
    lost_tick = 1'b0;
    debt_nxt  = debt;
    if (tick && !debt_dec) begin
      lost_tick = (debt == 3'd7);
      debt_nxt  = lost_tick ? debt : debt + 3'd1;
    end else if (debt_dec && !tick) begin
      debt_nxt = debt - 3'd1;
    end else begin
      debt_nxt = debt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     state_nxt = ((debt != 3'd0) || sr_req) ? ST_REQ : ST_IDLE;
      ST_REQ:      state_nxt = ref_gnt ? ST_PRE : ST_REQ;
      ST_PRE:      state_nxt = ST_PRE_WAIT;
      ST_PRE_WAIT: state_nxt = (phase != '0) ? ST_PRE_WAIT : (sr_req ? ST_SR_ENTER : ST_AREF);
      ST_AREF:     state_nxt = ST_RFC_WAIT;
      ST_RFC_WAIT: state_nxt = (phase != '0) ? ST_RFC_WAIT : ((debt != 3'd0) ? ST_AREF : ST_IDLE);
      ST_SR_ENTER: state_nxt = ST_SR_HOLD;
      ST_SR_HOLD:  state_nxt = sr_req ? ST_SR_HOLD : ST_SR_EXIT;
      ST_SR_EXIT:  state_nxt = sx_done ? ST_IDLE : ST_SR_EXIT;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      debt     <= 3'd0;
      phase    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_PRE:                   phase <= PH_TRP;
        ST_AREF:                  phase <= PH_TRFC;
        ST_PRE_WAIT, ST_RFC_WAIT: phase <= (phase != '0) ? phase - PH_ONE : phase;
        default:                  phase <= phase;
      endcase
      // Self-refresh discards pending debt; leaving it owes exactly one refresh.
      if (state == ST_SR_ENTER) begin
        debt <= 3'd0;
      end else if ((state == ST_SR_EXIT) && sx_done) begin
        debt <= 3'd1;
      end else begin
        debt <= debt_nxt;
      end
      overflow <= overflow | lost_tick;
    end
  end

  always_comb begin
    command  = CMD_NOP;
    cke      = 1'b1;
    ref_req  = (state != ST_IDLE);
    sr_ack   = 1'b0;
    sx_start = 1'b0;
    case (state)
      ST_PRE:      command = CMD_PRE;
      ST_AREF:     command = CMD_AREF;
      ST_SR_ENTER: begin
        command = CMD_AREF;
        cke     = 1'b0;
      end
      ST_SR_HOLD:  begin
        cke    = 1'b0;
        sr_ack = 1'b1;
      end
      ST_SR_EXIT:  begin
        sx_start = 1'b1;
        command  = sx_command;
      end
      default:     command = CMD_NOP;
    endcase
  end

  assign ref_overflow = overflow;

endmodule

// File: tb/tb_sdram_refresh_ctrl.sv
// Directed + randomized bench for sdram_refresh_ctrl with a debt/tick reference model.
module tb_sdram_refresh_ctrl;
  import sdram_pkg::*;

  localparam int INTERVAL = 16;
  localparam int T_RP     = 2;
  localparam int T_RFC    = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       ref_en = 1'b0;
  logic       ref_gnt = 1'b0;
  logic       sr_req = 1'b0;
  logic       sx_done = 1'b0;
  logic [3:0] sx_command = 4'b0111;
  logic       ref_req;
  logic       sr_ack;
  logic       sx_start;
  logic [3:0] command;
  logic       cke;
  logic       ref_overflow;

  int total = 0;
  int bad   = 0;

  // Reference model: enabled-cycle phase, outstanding refreshes, lost-tick flag.
  int tmr_m  = 0;
  int debt_m = 0;
  bit ovf_m  = 1'b0;
  bit hold_m = 1'b0;

  logic [3:0] got_q[$];
  logic [3:0] exp_q[$];

  sdram_refresh_ctrl #(
    .REF_INTERVAL(INTERVAL),
    .TRP         (T_RP),
    .TRFC        (T_RFC),
    .CNT_BITS    (4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .ref_en      (ref_en),
    .ref_gnt     (ref_gnt),
    .sr_req      (sr_req),
    .sx_done     (sx_done),
    .sx_command  (sx_command),
    .ref_req     (ref_req),
    .sr_ack      (sr_ack),
    .sx_start    (sx_start),
    .command     (command),
    .cke         (cke),
    .ref_overflow(ref_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then settle past the edge.
  task automatic cyc();
    if (!n_rst) begin
      tmr_m  = 0;
      debt_m = 0;
      ovf_m  = 1'b0;
    end else if (ref_en && !hold_m) begin
      tmr_m++;
      if (tmr_m == INTERVAL) begin
        tmr_m = 0;
        if (debt_m == 7) ovf_m = 1'b1;
        else debt_m++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Grant the bus and capture the command stream until the request drops.
  task automatic service(input string tag, input int n_aref, input bit drop_sr);
    exp_q = {};
    got_q = {};
    if (n_aref > 0) begin
      exp_q.push_back(CMD_PRE);
      for (int i = 0; i < T_RP; i++) exp_q.push_back(CMD_NOP);
      for (int k = 0; k < n_aref; k++) begin
        exp_q.push_back(CMD_AREF);
        for (int i = 0; i < T_RFC; i++) exp_q.push_back(CMD_NOP);
      end
    end
    ref_gnt = 1'b1;
    for (int i = 0; i < 200 && ref_req; i++) begin
      cyc();
      if (drop_sr) sr_req = 1'b0;
      if (ref_req) got_q.push_back(command);
    end
    ref_gnt = 1'b0;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_cmd%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    cyc();
    cyc();
    n_rst = 1'b1;
    chk("rst_cmd", command, CMD_NOP);
    chk("rst_cke", cke, 1'b1);
    chk("rst_req", ref_req, 1'b0);
    chk("rst_ack", sr_ack, 1'b0);
    chk("rst_sx", sx_start, 1'b0);
    chk("rst_ovf", ref_overflow, 1'b0);

    // Single interval with the bus always granted.
    ref_en  = 1'b1;
    ref_gnt = 1'b1;
    repeat (INTERVAL) cyc();
    chk("t1_req_before", ref_req, 1'b0);
    ref_en = 1'b0;
    cyc();
    chk("t1_req_after", ref_req, (debt_m > 0));
    service("t1", debt_m, 1'b0);
    debt_m = 0;

    // Three intervals accumulated without a grant.
    ref_gnt = 1'b0;
    ref_en  = 1'b1;
    repeat (3 * INTERVAL) cyc();
    ref_en = 1'b0;
    cyc();
    chk("t2_debt3", debt_m, 3);
    chk("t2_ovf", ref_overflow, ovf_m);
    service("t2", debt_m, 1'b0);
    debt_m = 0;

    // Eight-plus intervals saturate debt and flag overflow.
    ref_en = 1'b1;
    repeat (8 * INTERVAL + 2) cyc();
    ref_en = 1'b0;
    cyc();
    chk("t3_ovf", ref_overflow, ovf_m);
    service("t3", debt_m, 1'b0);
    debt_m = 0;
    chk("t3_ovf_sticky", ref_overflow, 1'b1);

    // Randomized enable patterns against the model.
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(60, 260);
      for (int c = 0; c < n; c++) begin
        ref_en = 1'($urandom_range(0, 1));
        cyc();
      end
      ref_en = 1'b0;
      cyc();
      chk($sformatf("rnd%0d_req", r), ref_req, (debt_m > 0));
      chk($sformatf("rnd%0d_ovf", r), ref_overflow, ovf_m);
      service($sformatf("rnd%0d", r), debt_m, 1'b0);
      debt_m = 0;
    end

    // Self-refresh entry, hold and exit handshake.
    ref_gnt = 1'b1;
    sr_req  = 1'b1;
    cyc();
    chk("sr_req_hi", ref_req, 1'b1);
    cyc();
    chk("sr_pre", command, CMD_PRE);
    repeat (T_RP) cyc();
    chk("sr_trp_nop", command, CMD_NOP);
    cyc();
    chk("sr_enter_cmd", command, CMD_AREF);
    chk("sr_enter_cke", cke, 1'b0);
    hold_m = 1'b1;
    tmr_m  = 0;
    debt_m = 0;
    ref_en = 1'b1;
    cyc();
    chk("sr_hold_ack", sr_ack, 1'b1);
    chk("sr_hold_cke", cke, 1'b0);
    chk("sr_hold_cmd", command, CMD_NOP);
    repeat (3 * INTERVAL) cyc();
    chk("sr_hold_ack2", sr_ack, 1'b1);
    sr_req = 1'b0;
    cyc();
    chk("sx_cke", cke, 1'b1);
    chk("sx_start", sx_start, 1'b1);
    chk("sx_ack", sr_ack, 1'b0);
    for (int j = 0; j < 3; j++) begin
      sx_command = 4'($urandom_range(0, 15));
      #1;
      chk($sformatf("sx_cmd%0d", j), command, sx_command);
      cyc();
    end
    sx_done = 1'b1;
    cyc();
    sx_done = 1'b0;
    ref_en  = 1'b0;
    hold_m  = 1'b0;
    debt_m  = 1;
    chk("sx_start_low", sx_start, 1'b0);
    chk("sx_idle_req", ref_req, 1'b0);
    cyc();
    chk("sx_post_req", ref_req, 1'b1);
    service("sx_post", debt_m, 1'b0);
    debt_m = 0;

    // Self-refresh request withdrawn during precharge takes the refresh branch.
    sr_req = 1'b1;
    cyc();
    service("sr_drop", 1, 1'b1);
    cyc();
    chk("sr_drop_idle", ref_req, 1'b0);

    // Reset during RFC_WAIT.
    ref_en = 1'b1;
    repeat (2 * INTERVAL) cyc();
    ref_en = 1'b0;
    cyc();
    ref_gnt = 1'b1;
    repeat (1 + T_RP + 1 + 2) cyc();
    chk("r1_in_rfc", command, CMD_NOP);
    chk("r1_in_rfc_req", ref_req, 1'b1);
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    chk("r1_cmd", command, CMD_NOP);
    chk("r1_cke", cke, 1'b1);
    chk("r1_req", ref_req, 1'b0);
    chk("r1_ovf", ref_overflow, ovf_m);
    cyc();
    chk("r1_debt0", ref_req, (debt_m > 0));

    // Reset during SR_HOLD.
    sr_req = 1'b1;
    repeat (1 + 1 + T_RP + 1 + 1) cyc();
    chk("r2_in_hold", sr_ack, 1'b1);
    chk("r2_in_hold_cke", cke, 1'b0);
    n_rst  = 1'b0;
    sr_req = 1'b0;
    cyc();
    n_rst = 1'b1;
    chk("r2_cke", cke, 1'b1);
    chk("r2_ack", sr_ack, 1'b0);
    chk("r2_req", ref_req, 1'b0);
    chk("r2_cmd", command, CMD_NOP);
    ref_gnt = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
